fp_cmp_scheduler: RTL
=====================

# fp_cmp_scheduler

Round-robin scheduler that shares one pipelined FloPoCo 11/18 floating-point subtractor among `NREQ` comparison requesters in the ray/AABB intersection datapath. Each request carries two operands A and B. The block issues at most one request per cycle to the subtractor and tracks each in-flight request with a tag pipeline. It decodes the difference A-B into a greater-or-equal verdict and returns the verdict to the originating requester. It replaces per-slab private comparators in the tmin/tmax reduction stage.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `SUB_LAT`, 2: subtractor latency in cycles, ≥1. Must match `fp_sub_pipe`.
- `W`, 32: operand width. Layout is exc[31:30], sign[29], exp[28:18], frac[17:0].
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_a`  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- `req_b`  in  NREQ*W  operand B, same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot grant; a request is accepted when valid&ready.
- `rsp_valid`  out  NREQ  one-hot response strobe, one cycle.
- `rsp_ge`  out  1  result: 1 when A ≥ B.
- `rsp_nan`  out  1  result: 1 when A-B is NaN.
- `busy`  out  1  1 when any request is in flight.

## Operation
- **Arbitration:** combinational round-robin over `req_valid`, starting at pointer `rr`.
  - At most one bit of `req_ready` is set; it is the first valid index at or after `rr`, modulo NREQ.
  - `req_ready` is all-zero when no request is valid.
- **Pointer update:** on an accepted grant to index g, `rr` becomes (g+1) mod NREQ. With no grant, `rr` holds.
- **Issue:** the mux drives the granted `req_a`/`req_b` to `fp_sub_pipe` in the same cycle as the grant. Idle cycles drive zeros.
- **Tag pipeline:** SUB_LAT stages, each holding {vld, id[$clog2(NREQ)-1:0]}.
  - Stage 0 loads {grant, g}.
  - The tag shifts every cycle; there is no stall.
- **Decode** of subtractor output R, applied when the tag at stage SUB_LAT-1 is valid:
  - exc=00 (zero): ge=1, nan=0.
  - exc=01 or exc=10 (normal or inf), sign=0: ge=1, nan=0.
  - exc=01 or exc=10, sign=1: ge=0, nan=0.
  - exc=11 (NaN): ge=0, nan=1.
- **Response:** registered. `rsp_valid` is one-hot on id, and `rsp_ge`/`rsp_nan` are held. When no response is issued, `rsp_valid`=0 and `rsp_ge`/`rsp_nan` keep their last values.
- **No response backpressure.** Requesters must sink `rsp_valid` every cycle.
- **Out-of-order risk:** a requester may issue back-to-back. Responses to the same requester return in issue order.
- **busy:** the OR of all tag vld bits and the response register valid.

## Timing
- **Reset values:** `rr`=0, all tag vld=0, `rsp_valid`=0, `rsp_ge`=0, `rsp_nan`=0, `busy`=0.
- `req_ready` is combinational and may be nonzero during reset deassertion; it has no effect while rst=1.
- **Latency:** a request accepted at cycle t produces its `rsp_valid` at t+SUB_LAT+1.
- **Throughput:** 1 comparison/cycle aggregate.
- **Fairness:** with all NREQ valid continuously, each requester is granted exactly once per NREQ cycles.
- **Simultaneous events:** a new grant and a response retiring in the same cycle are independent; both proceed.
- **Reset mid-operation:** all in-flight tags are dropped and no response is ever produced for them. The subtractor's internal state is don't-care because the tags are cleared.
- **Dropped valid:** a requester that deasserts `req_valid` without ready loses nothing; no state is kept per request.

## Structure
- **Package `fp_cmp_pkg`:**
  - Constants `FP_W`=32, `EXC_HI`=31, `EXC_LO`=30, `SIGN_BIT`=29.
  - Exception codes `EXC_ZERO`=2'b00, `EXC_NORM`=2'b01, `EXC_INF`=2'b10, `EXC_NAN`=2'b11.
  - Function `fp_ge_decode(R)` returning {ge,nan}.
- **Sub-module `fp_sub_pipe`:** thin wrapper that instantiates the FloPoCo FPSub 11/18 core and exports `SUB_LAT`. It is the only instance inside `fp_cmp_scheduler`.
- **Top-level contents:** the round-robin arbiter, the operand mux, the tag shift register and the response register.

## Test plan
- **Single compare, equal operands:** requester 0 sends A=0x4FFC0000 (1.0), B=0x4FFC0000. Expect `rsp_valid`=0001 at t+SUB_LAT+1, ge=1 (zero difference), nan=0.
- **Ordering by sign of difference:** requester 2 sends A=0x4FFC0000 (1.0), B=0x50000000 (2.0); expect ge=0. Swapped operands: expect ge=1.
- **Special values:**
  - A=0x80000000 (+inf), B=0x4FFC0000: expect ge=1.
  - A=0xC0000000 (NaN), any B: expect ge=0, nan=1.
- **Fairness:** all four `req_valid` held high for 8 cycles. Expect grant sequence 0,1,2,3,0,1,2,3. Each response arrives on the matching `rsp_valid` bit, SUB_LAT+1 cycles after its grant.
- **Sparse requests and pointer:** only requester 3 valid, then only requester 1 valid. Expect grants to 3 then 1, and `rr` equal to 0 then 2.
- **Reset mid-flight:** issue 3 requests, then assert rst on the cycle after the third grant. Expect no `rsp_valid` afterwards, `busy`=0 and `rr`=0. After release, a fresh request completes normally.

Source files
------------

// File: rtl/fp_cmp_pkg.sv
// Shared field positions, exception codes and the A-B verdict decode for the
// FloPoCo 11/18 comparison scheduler.
package fp_cmp_pkg;

    localparam int FP_W     = 32;
    localparam int EXC_HI   = 31;
    localparam int EXC_LO   = 30;
    localparam int SIGN_BIT = 29;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    typedef struct packed {
        logic ge;
        logic nan;
    } cmp_res_t;

    function automatic cmp_res_t fp_ge_decode(input logic [FP_W-1:0] r);
        cmp_res_t res;
        case (r[EXC_HI:EXC_LO])
            EXC_ZERO:          res = '{ge: 1'b1, nan: 1'b0};
            EXC_NORM, EXC_INF: res = '{ge: ~r[SIGN_BIT], nan: 1'b0};
            EXC_NAN:           res = '{ge: 1'b0, nan: 1'b1};
            default:           res = '{ge: 1'b0, nan: 1'b1};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fp_cmp_scheduler_sub.sv
// FloPoCo-format (wE=11, wF=18) subtractor R = A - B with a SUB_LAT-deep result
// pipeline; the magnitude path truncates, the sign and exception path is exact.
module fp_sub_pipe
    import fp_cmp_pkg::*;
#(
    parameter int SUB_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] r
);

    logic               sa_s, sb_s, swap_s, sbig_s, eff_sub_s;
    logic [1:0]         xa_s, xb_s;
    logic [28:0]        mbig_s, msml_s;
    logic [10:0]        ediff_s;
    logic [21:0]        mant_big_s, mant_sml_s;
    logic [22:0]        sum_s;
    logic [4:0]         lead_s;
    logic signed [12:0] rexp_s;
    logic [17:0]        frac_s;
    logic [FP_W-1:0]    diff_s;
    logic [FP_W-1:0]    stage_r [SUB_LAT];

    // Align, add/subtract, normalise; B's sign is flipped so this is A + (-B)
    always_comb begin
        sa_s       = a[SIGN_BIT];
        sb_s       = ~b[SIGN_BIT];
        xa_s       = a[EXC_HI:EXC_LO];
        xb_s       = b[EXC_HI:EXC_LO];
        swap_s     = (b[28:0] > a[28:0]);
        mbig_s     = swap_s ? b[28:0] : a[28:0];
        msml_s     = swap_s ? a[28:0] : b[28:0];
        sbig_s     = swap_s ? sb_s : sa_s;
        eff_sub_s  = sa_s ^ sb_s;
        ediff_s    = mbig_s[28:18] - msml_s[28:18];
        mant_big_s = {1'b1, mbig_s[17:0], 3'b000};
        mant_sml_s = (ediff_s > 11'd21) ? 22'd0 : ({1'b1, msml_s[17:0], 3'b000} >> ediff_s);
        if (eff_sub_s) begin
            sum_s = {1'b0, mant_big_s} - {1'b0, mant_sml_s};
        end else begin
            sum_s = {1'b0, mant_big_s} + {1'b0, mant_sml_s};
        end
        lead_s = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (sum_s[i]) begin
                lead_s = 5'(i);
            end else begin
                lead_s = lead_s;
            end
        end
        frac_s = 18'((sum_s << (5'd22 - lead_s)) >> 4);
        rexp_s = 13'(mbig_s[28:18]) + 13'(lead_s) - 13'd21;

        if (xa_s == EXC_NAN || xb_s == EXC_NAN) begin
            diff_s = {EXC_NAN, 30'd0};
        end else if (xa_s == EXC_INF && xb_s == EXC_INF) begin
            diff_s = (sa_s == sb_s) ? {EXC_INF, sa_s, 29'd0} : {EXC_NAN, 30'd0};
        end else if (xa_s == EXC_INF) begin
            diff_s = {EXC_INF, sa_s, 29'd0};
        end else if (xb_s == EXC_INF) begin
            diff_s = {EXC_INF, sb_s, 29'd0};
        end else if (xa_s == EXC_ZERO && xb_s == EXC_ZERO) begin
            diff_s = {EXC_ZERO, sa_s & sb_s, 29'd0};
        end else if (xa_s == EXC_ZERO) begin
            diff_s = {xb_s, sb_s, b[28:0]};
        end else if (xb_s == EXC_ZERO) begin
            diff_s = a;
        end else if (sum_s == 23'd0) begin
            diff_s = {EXC_ZERO, 30'd0};
        end else if (rexp_s < 13'sd0) begin
            diff_s = {EXC_ZERO, sbig_s, 29'd0};
        end else if (rexp_s > 13'sd2047) begin
            diff_s = {EXC_INF, sbig_s, 29'd0};
        end else begin
            diff_s = {EXC_NORM, sbig_s, rexp_s[10:0], frac_s};
        end
    end

    // Fixed-latency result pipeline matching the core depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SUB_LAT; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= diff_s;
            for (int i = 1; i < SUB_LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign r = stage_r[SUB_LAT-1];

endmodule

// File: rtl/fp_cmp_scheduler.sv
// Round-robin sharing of one pipelined FP subtractor among NREQ comparison
// requesters; a tag pipeline routes each A>=B verdict back to its requester.
module fp_cmp_scheduler
    import fp_cmp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SUB_LAT = 2,
    parameter int W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic              rsp_ge,
    output logic              rsp_nan,
    output logic              busy
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]     rr_r, cand_s, grant_idx_s;
    logic               grant_any_s;
    logic [W-1:0]       sub_a_s, sub_b_s, sub_r_s;
    logic [SUB_LAT-1:0] tag_vld_r;
    logic [IDW-1:0]     tag_id_r [SUB_LAT];
    cmp_res_t           dec_s;

    // Round-robin pick: first valid requester at or after the pointer
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        req_ready   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IDW'((int'(rr_r) + k) % NREQ);
            if (!grant_any_s && req_valid[cand_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        if (grant_any_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Operand mux into the shared subtractor; zeros on idle cycles
    always_comb begin
        if (grant_any_s) begin
            sub_a_s = req_a[grant_idx_s*W +: W];
            sub_b_s = req_b[grant_idx_s*W +: W];
        end else begin
            sub_a_s = '0;
            sub_b_s = '0;
        end
    end

    fp_sub_pipe #(.SUB_LAT(SUB_LAT)) u_sub (
        .clk (clk),
        .rst (rst),
        .a   (sub_a_s),
        .b   (sub_b_s),
        .r   (sub_r_s)
    );

    // Pointer moves just past the granted requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_r <= '0;
        end else if (grant_any_s) begin
            rr_r <= (int'(grant_idx_s) == NREQ - 1) ? '0 : grant_idx_s + IDW'(1);
        end else begin
            rr_r <= rr_r;
        end
    end

    // Tag shift register tracking who owns each subtractor stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_r <= '0;
            for (int i = 0; i < SUB_LAT; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_vld_r[0] <= grant_any_s;
            tag_id_r[0]  <= grant_idx_s;
            for (int i = 1; i < SUB_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_id_r[i]  <= tag_id_r[i-1];
            end
        end
    end

    assign dec_s = fp_ge_decode(sub_r_s);

    // Response register; verdict bits hold between responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_ge    <= 1'b0;
            rsp_nan   <= 1'b0;
        end else if (tag_vld_r[SUB_LAT-1]) begin
            rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << tag_id_r[SUB_LAT-1];
            rsp_ge    <= dec_s.ge;
            rsp_nan   <= dec_s.nan;
        end else begin
            rsp_valid <= '0;
            rsp_ge    <= rsp_ge;
            rsp_nan   <= rsp_nan;
        end
    end

    assign busy = (|tag_vld_r) | (|rsp_valid);

endmodule
